// File: rtl/chunker.sv
// Parallel-to-chunk serializer: captures an L-bit word on a strobe and emits it
// as L/M registered M-bit chunks, most significant chunk first, with a valid flag.
module chunker #(
    parameter int L = 8,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [L-1:0] data_in,
    input  logic         strobe,
    output logic [M-1:0] q,
    output logic         valid
);

    localparam int NR = L / M;
    localparam int CW = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NR - 1);

    generate
        if (M < 1 || M > L || (L % M) != 0) begin : g_bad_params
            $error("chunker: L must be a positive multiple of M with 1 <= M <= L");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [L-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [M-1:0]   q_q,     q_d;
    logic           valid_q, valid_d;

    // The shift register holds only the chunks not yet presented, top-aligned,
    // so the next chunk is always its top M bits.
    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = valid_q;

        if (strobe) begin
            shreg_d = data_in << M;
            q_d     = data_in[L-1 -: M];
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    q_d     = '0;
                    valid_d = 1'b0;
                end
                SHIFT: begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d   = cnt_q + 1'b1;
                        q_d     = shreg_q[L-1 -: M];
                        shreg_d = shreg_q << M;
                    end else begin
                        state_d = IDLE;
                        q_d     = '0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_chunker.sv
// Directed self-checking bench for chunker: default 8/2 instance plus a
// parameter sweep of 8/1, 8/4, 8/8 and 12/3 instances sharing one strobe.
module tb_chunker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Default instance, L=8 M=2
    logic [7:0] data_in;
    logic       strobe;
    logic [1:0] q;
    logic       valid;

    chunker #(.L(8), .M(2)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .strobe(strobe), .q(q), .valid(valid)
    );

    // Sweep instances
    logic        sw_strobe;
    logic [7:0]  d1, d4, d8;
    logic [11:0] d12;
    logic [0:0]  q1;
    logic [3:0]  q4;
    logic [7:0]  q8;
    logic [2:0]  q12;
    logic        v1, v4, v8, v12;

    chunker #(.L(8), .M(1)) dut_8_1 (
        .clk(clk), .reset(reset), .data_in(d1), .strobe(sw_strobe), .q(q1), .valid(v1)
    );
    chunker #(.L(8), .M(4)) dut_8_4 (
        .clk(clk), .reset(reset), .data_in(d4), .strobe(sw_strobe), .q(q4), .valid(v4)
    );
    chunker #(.L(8), .M(8)) dut_8_8 (
        .clk(clk), .reset(reset), .data_in(d8), .strobe(sw_strobe), .q(q8), .valid(v8)
    );
    chunker #(.L(12), .M(3)) dut_12_3 (
        .clk(clk), .reset(reset), .data_in(d12), .strobe(sw_strobe), .q(q12), .valid(v12)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect valid/q on the default instance
    task automatic exp_out(input string tag, input logic v, input logic [1:0] c);
        chk({tag, ".valid"}, 16'(valid), 16'(v));
        chk({tag, ".q"}, 16'(q), 16'(c));
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  w1, w4, w8;
        logic [11:0] w12;
        logic [15:0] e;

        reset     = 1'b0;
        strobe    = 1'b0;
        data_in   = 8'h00;
        sw_strobe = 1'b0;
        d1 = 8'h00; d4 = 8'h00; d8 = 8'h00; d12 = 12'h000;
        #12;
        exp_out("reset", 1'b0, 2'b00);
        chk("reset.v1", 16'(v1), 16'h0);
        chk("reset.v12", 16'(v12), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        exp_out("idle_after_reset", 1'b0, 2'b00);

        // 1: single word 0x69 -> 01,10,10,01; data_in change after strobe ignored
        data_in = 8'b01101001; strobe = 1'b1;
        tick();
        strobe = 1'b0; data_in = 8'hFF;
        exp_out("t1.c0", 1'b1, 2'b01);
        tick(); exp_out("t1.c1", 1'b1, 2'b10);
        tick(); exp_out("t1.c2", 1'b1, 2'b10);
        tick(); exp_out("t1.c3", 1'b1, 2'b01);
        tick(); exp_out("t1.end", 1'b0, 2'b00);
        repeat (8) tick();
        exp_out("t1.idle", 1'b0, 2'b00);

        // 2: same word again, no residue
        data_in = 8'b01101001; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        exp_out("t2.c0", 1'b1, 2'b01);
        tick(); exp_out("t2.c1", 1'b1, 2'b10);
        tick(); exp_out("t2.c2", 1'b1, 2'b10);
        tick(); exp_out("t2.c3", 1'b1, 2'b01);
        tick(); exp_out("t2.end", 1'b0, 2'b00);

        // 3: abort A=0xA5 after its first chunk with B=0x3C
        data_in = 8'hA5; strobe = 1'b1;
        tick();
        exp_out("t3.a0", 1'b1, 2'b10);
        data_in = 8'h3C;
        tick();
        strobe = 1'b0;
        exp_out("t3.b0", 1'b1, 2'b00);
        tick(); exp_out("t3.b1", 1'b1, 2'b11);
        tick(); exp_out("t3.b2", 1'b1, 2'b11);
        tick(); exp_out("t3.b3", 1'b1, 2'b00);
        tick(); exp_out("t3.end", 1'b0, 2'b00);

        // 4: back-to-back, strobe on the last-chunk cycle, next word 0xE4
        data_in = 8'h69; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        exp_out("t4.a0", 1'b1, 2'b01);
        tick(); tick(); tick();
        exp_out("t4.a3", 1'b1, 2'b01);
        data_in = 8'hE4; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        exp_out("t4.b0", 1'b1, 2'b11);
        tick(); exp_out("t4.b1", 1'b1, 2'b10);
        tick(); exp_out("t4.b2", 1'b1, 2'b01);
        tick(); exp_out("t4.b3", 1'b1, 2'b00);
        tick(); exp_out("t4.end", 1'b0, 2'b00);

        // 5: async reset during chunk 2 of 0xA5 (10,10,01,01)
        data_in = 8'hA5; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        exp_out("t5.c2", 1'b1, 2'b01);
        #1 reset = 1'b0;
        #1;
        exp_out("t5.async", 1'b0, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        tick(); tick(); tick();
        exp_out("t5.idle", 1'b0, 2'b00);

        // 6: parameter sweep, all instances strobed together
        w1 = 8'hB2; w4 = 8'h5C; w8 = 8'h9E; w12 = 12'hD2B;
        d1 = w1; d4 = w4; d8 = w8; d12 = w12; sw_strobe = 1'b1;
        tick();
        sw_strobe = 1'b0;
        d1 = 8'h00; d4 = 8'h00; d8 = 8'h00; d12 = 12'h000;
        for (int k = 0; k < 9; k++) begin
            e = 16'h0;
            if (k < 8) e = 16'(w1[7-k]);
            chk($sformatf("sw8_1.k%0d.v", k), 16'(v1), 16'(k < 8));
            chk($sformatf("sw8_1.k%0d.q", k), 16'(q1), e);
            e = 16'h0;
            if (k < 2) e = 16'(w4[(1-k)*4 +: 4]);
            chk($sformatf("sw8_4.k%0d.v", k), 16'(v4), 16'(k < 2));
            chk($sformatf("sw8_4.k%0d.q", k), 16'(q4), e);
            e = 16'h0;
            if (k < 1) e = 16'(w8);
            chk($sformatf("sw8_8.k%0d.v", k), 16'(v8), 16'(k < 1));
            chk($sformatf("sw8_8.k%0d.q", k), 16'(q8), e);
            e = 16'h0;
            if (k < 4) e = 16'(w12[(3-k)*3 +: 3]);
            chk($sformatf("sw12_3.k%0d.v", k), 16'(v12), 16'(k < 4));
            chk($sformatf("sw12_3.k%0d.q", k), 16'(q12), e);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
